// File: rtl/key_debounce_display_pkg.sv
// Shared constants for the key debounce / 7-segment counter slice.
package key_debounce_display_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned COUNT_W    = NUM_DIGITS * DIGIT_W;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  // Board defaults at 50 MHz: 20 ms debounce, 1 ms per digit
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_SCAN_CYCLES     = 50_000;

  // Active-low common-anode codes {dp,g,f,e,d,c,b,a}, index = BCD digit
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Segment pattern for one BCD digit; anything above 9 is blanked
  function automatic logic [SEG_W-1:0] seg_code(input logic [DIGIT_W-1:0] digit);
    logic [SEG_W-1:0] code;
    code = SEG_BLANK;
    if (digit <= DIGIT_W'(9)) begin
      code = SEG_TABLE[digit];
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce_display_key_filter.sv
// Synchronises and debounces an active-low key; pulses once per qualified press.
module key_filter
  import key_debounce_display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             key_s;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             stable_d_q;

  assign key_s = sync_q[1];

  // Two-flop synchroniser; idles at released (1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_raw};
    end
  end

  // Stable state flips only after key_s differs for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else if (key_s == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q    <= '0;
      stable_q <= key_s;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // One-cycle pulse the cycle after the stable state falls; release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d_q <= 1'b1;
      press      <= 1'b0;
    end else begin
      stable_d_q <= stable_q;
      press      <= stable_d_q & ~stable_q;
    end
  end

endmodule

// File: rtl/key_debounce_display.sv
// Counts debounced key presses in 6-digit BCD and scans them onto a 7-segment display.
module key_debounce_display
  import key_debounce_display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SCAN_CYCLES     = DEF_SCAN_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key1,
  output logic [NUM_DIGITS-1:0] seg_sel,
  output logic [SEG_W-1:0]      seg_data
);

  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic                press;
  logic [COUNT_W-1:0]  bcd_count;
  logic [COUNT_W-1:0]  count_inc;
  logic                carry;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic [DIGIT_W-1:0]  cur_digit;

  key_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(key1),
    .press  (press)
  );

  // Ripple BCD increment; a 9 rolls to 0 and carries into the next digit
  always_comb begin
    count_inc = bcd_count;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (bcd_count[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(9)) begin
          count_inc[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          count_inc[i*DIGIT_W +: DIGIT_W] = bcd_count[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
    end
  end

  // Press counter; holds between presses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_count <= '0;
    end else if (press) begin
      bcd_count <= count_inc;
    end
  end

  // Digit scan: each digit held SCAN_CYCLES cycles, index wraps after the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Select the BCD digit under the current scan index
  always_comb begin
    cur_digit = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_digit = bcd_count[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Registered display drive, one cycle behind index/count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel  <= '1;
      seg_data <= SEG_BLANK;
    end else begin
      seg_sel  <= ~(NUM_DIGITS'(1) << digit_idx);
      seg_data <= seg_code(cur_digit);
    end
  end

endmodule

// File: tb/tb_key_debounce_display.sv
// Directed bench for key_debounce_display with short debounce/scan periods.
module tb_key_debounce_display;

  localparam int unsigned DEB  = 16;
  localparam int unsigned SCAN = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key1  = 1'b1;
  logic [5:0] seg_sel;
  logic [7:0] seg_data;

  int passed = 0;
  int total  = 0;

  logic [7:0] seg_ref [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  key_debounce_display #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_CYCLES    (SCAN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key1    (key1),
    .seg_sel (seg_sel),
    .seg_data(seg_data)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int lo, input int hi);
    key1 = 1'b0;
    cycles(lo);
    key1 = 1'b1;
    cycles(hi);
  endtask

  // Reads all six digits off the scanned display and compares with val
  task automatic check_count(input string tag, input int unsigned val);
    int unsigned div;
    int unsigned d;
    logic [5:0]  exp_sel;
    bit          found;
    div = 1;
    for (int i = 0; i < 6; i++) begin
      d       = (val / div) % 10;
      exp_sel = ~(6'b000001 << i);
      found   = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        if (seg_sel === exp_sel) found = 1'b1;
      end
      chk($sformatf("%s_sel%0d", tag, i), {2'b00, seg_sel}, {2'b00, exp_sel});
      chk($sformatf("%s_dig%0d", tag, i), seg_data, seg_ref[d]);
      div = div * 10;
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    key1  = 1'b1;
    cycles(3);
    chk("rst_sel", {2'b00, seg_sel}, 8'h3F);
    chk("rst_data", seg_data, 8'hFF);
    rst_n = 1'b1;

    // Scan order after reset, each digit held SCAN cycles, all zeros
    for (int k = 0; k < 24; k++) begin
      logic [5:0] exp_sel;
      @(negedge clk);
      exp_sel = ~(6'b000001 << ((k / 4) % 6));
      chk($sformatf("scan_sel_%0d", k), {2'b00, seg_sel}, {2'b00, exp_sel});
      chk($sformatf("scan_data_%0d", k), seg_data, 8'hC0);
    end

    // Clean press
    press(40, 40);
    check_count("clean", 1);

    // Bouncy press then bouncy release
    key1 = 1'b0; cycles(3);
    key1 = 1'b1; cycles(5);
    key1 = 1'b0; cycles(7);
    key1 = 1'b1; cycles(4);
    key1 = 1'b0; cycles(10);
    key1 = 1'b1; cycles(3);
    key1 = 1'b0; cycles(40);
    key1 = 1'b1; cycles(4);
    key1 = 1'b0; cycles(6);
    key1 = 1'b1; cycles(9);
    key1 = 1'b0; cycles(3);
    key1 = 1'b1; cycles(40);
    check_count("bounce", 2);

    // Glitch boundary: 15 cycles rejected, 16 accepted
    press(15, 30);
    check_count("glitch15", 2);
    press(16, 30);
    check_count("glitch16", 3);

    // Carry into the tens digit
    for (int p = 0; p < 7; p++) press(20, 20);
    check_count("carry10", 10);

    // Reset in the middle of qualification
    key1 = 1'b0;
    cycles(12);
    rst_n = 1'b0;
    cycles(1);
    chk("midrst_sel", {2'b00, seg_sel}, 8'h3F);
    chk("midrst_data", seg_data, 8'hFF);
    rst_n = 1'b1;
    cycles(1);
    chk("postrst_sel", {2'b00, seg_sel}, 8'h3E);
    chk("postrst_data", seg_data, 8'hC0);
    cycles(3);
    chk("postrst_d0_still0", seg_data, 8'hC0);
    cycles(21);
    chk("postrst_sel25", {2'b00, seg_sel}, 8'h3E);
    chk("postrst_d0_one", seg_data, 8'hF9);
    key1 = 1'b1;
    cycles(40);
    check_count("after_rst", 1);

    // Wrap from 999999
    force dut.bcd_count = 24'h999999;
    cycles(1);
    release dut.bcd_count;
    check_count("preload", 999999);
    press(20, 20);
    check_count("wrap", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
